// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: ROWS x COLS active-low matrix scanner with whole-frame
// debounce, multi-key press/release event generation and a small event FIFO.
module keypad_matrix_scan #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
  localparam int N              = ROWS * COLS,
  localparam int CODE_W         = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic [N-1:0]      key_state,
  output logic              any_pressed,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press,
  output logic              overflow
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RUN_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ROWS-1:0]   ROW_ONE   = ROWS'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(DEBOUNCE_FRAMES);
  localparam logic [CODE_W-1:0] IDX_LAST  = CODE_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_ROW, S_EVAL, S_EMIT} state_t;

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } evt_t;

  state_t                     state_q, state_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [SET_W-1:0]           settle_q, settle_d;
  logic [N-1:0]               raw_q, raw_d;
  logic [N-1:0]               prev_q, prev_d;
  logic [RUN_W-1:0]           run_q, run_d, run_new;
  logic [N-1:0]               key_q, key_d;
  logic [N-1:0]               diff_q, diff_d;
  logic [CODE_W-1:0]          idx_q, idx_d;
  logic                       push;
  evt_t                       push_evt;

  evt_t [FIFO_DEPTH-1:0]      mem_q, mem_d;
  logic [PTR_W-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       vld_q, vld_d;
  evt_t                       head_q, head_d;
  logic                       ovf_q, ovf_d;
  logic                       pop, accept;

  // Scan / debounce / emit FSM: next state, row drive and event push request.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    run_d    = run_q;
    key_d    = key_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    push     = 1'b0;
    push_evt = '0;
    row_n    = '1;
    run_new  = run_q;
    case (state_q)
      S_ROW: begin
        row_n = ~(ROW_ONE << row_q);
        if (settle_q == SET_LAST) begin
          raw_d[row_q*COLS +: COLS] = ~col_n;
          settle_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_EVAL;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_EVAL: begin
        // A frame counts toward the run only if it matches the previous one.
        if (raw_q == prev_q) run_new = (run_q < RUN_MAX) ? run_q + RUN_W'(1) : RUN_MAX;
        else                 run_new = RUN_W'(1);
        run_d  = run_new;
        prev_d = raw_q;
        if (run_new >= RUN_MAX && raw_q != key_q) begin
          key_d   = raw_q;
          diff_d  = raw_q ^ key_q;
          idx_d   = '0;
          state_d = S_EMIT;
        end else begin
          row_d    = '0;
          settle_d = '0;
          state_d  = S_ROW;
        end
      end
      S_EMIT: begin
        // key_q already holds the committed state, so it gives the event type.
        if (diff_q[idx_q]) begin
          push           = 1'b1;
          push_evt.press = key_q[idx_q];
          push_evt.code  = idx_q;
        end
        if (idx_q == IDX_LAST) begin
          row_d    = '0;
          settle_d = '0;
          state_d  = S_ROW;
        end else begin
          idx_d = idx_q + CODE_W'(1);
        end
      end
      default: begin
        row_d    = '0;
        settle_d = '0;
        state_d  = S_ROW;
      end
    endcase
  end

  // Event FIFO: a full FIFO still accepts a push when the head is popped
  // in the same cycle; head outputs are registered from the next-state image.
  always_comb begin
    pop    = vld_q && evt_ready;
    accept = push && ((cnt_q < CNT_FULL) || pop);
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = push && !accept;
    if (accept) begin
      mem_d[wr_q] = push_evt;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    cnt_d  = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    vld_d  = (cnt_d != '0);
    head_d = head_q;
    if (vld_d) head_d = mem_d[rd_d];
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ROW;
      row_q    <= '0;
      settle_q <= '0;
      raw_q    <= '0;
      prev_q   <= '0;
      run_q    <= '0;
      key_q    <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      key_q    <= key_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign key_state   = key_q;
  assign any_pressed = |key_q;
  assign evt_valid   = vld_q;
  assign evt_code    = head_q.code;
  assign evt_press   = head_q.press;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan: a key-matrix model drives col_n from
// row_n, a monitor logs popped events, and every check goes through chk().
module tb_keypad_matrix_scan;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [N-1:0]  key_state;
  logic          any_pressed, evt_valid, evt_ready, evt_press, overflow;
  logic [CW-1:0] evt_code;
  logic [N-1:0]  keys;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] evq[$];
  int         ovf_cnt = 0;
  bit         seen_vld = 1'b0;

  keypad_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(2), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .key_state(key_state), .any_pressed(any_pressed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_press(evt_press), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  // Event monitor on the falling edge: logs {press, code} of every pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid) seen_vld = 1'b1;
      if (evt_valid && evt_ready) evq.push_back({evt_press, evt_code});
      if (overflow) ovf_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ones();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (row_n == '1) begin ok = 1'b1; break; end
      tick();
    end
    chk("tmo_idle", 32'(ok), 32'd1);
  endtask

  task automatic wait_scan();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (row_n != '1) begin ok = 1'b1; break; end
      tick();
    end
    chk("tmo_scan", 32'(ok), 32'd1);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) begin wait_ones(); wait_scan(); end
  endtask

  // Key changes land between frames so every frame sees a consistent matrix.
  task automatic set_keys(input logic [N-1:0] v);
    wait_ones();
    keys = v;
  endtask

  logic [3:0] rs [9] = '{4'he, 4'he, 4'hd, 4'hd, 4'hb, 4'hb, 4'h7, 4'h7, 4'hf};

  initial begin
    int m;
    int o;
    int run;
    bit ok;
    keys = '0;
    evt_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_row_n", 32'(row_n), 32'h e);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_any", 32'(any_pressed), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_code", 32'(evt_code), 32'h0);
    chk("rst_press", 32'(evt_press), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // 1: idle scan, two frames of exact row sequence
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      chk("row_seq", 32'(row_n), 32'(rs[k % 9]));
      tick();
    end
    wait_frames(3);
    chk("idle_key_state", 32'(key_state), 32'h0);
    chk("idle_no_valid", 32'(seen_vld), 32'h0);

    // 2: single key 6 press and release
    m = evq.size();
    set_keys(16'h0040);
    wait_frames(4);
    chk("k6_state", 32'(key_state), 32'h0040);
    chk("k6_any", 32'(any_pressed), 32'h1);
    chk("k6_nevt", 32'(evq.size() - m), 32'd1);
    chk("k6_evt", 32'(evq[m]), 32'h16);
    m = evq.size();
    set_keys(16'h0000);
    wait_frames(4);
    chk("k6_rel_state", 32'(key_state), 32'h0);
    chk("k6_rel_any", 32'(any_pressed), 32'h0);
    chk("k6_rel_nevt", 32'(evq.size() - m), 32'd1);
    chk("k6_rel_evt", 32'(evq[m]), 32'h06);

    // 3: one-frame bounce produces nothing
    m = evq.size();
    set_keys(16'h0040);
    wait_frames(1);
    set_keys(16'h0000);
    wait_frames(4);
    chk("bounce_state", 32'(key_state), 32'h0);
    chk("bounce_nevt", 32'(evq.size() - m), 32'd0);

    // 4: codes 3 and 12 together, ascending order
    m = evq.size();
    set_keys(16'h1008);
    wait_frames(4);
    chk("two_state", 32'(key_state), 32'h1008);
    chk("two_nevt", 32'(evq.size() - m), 32'd2);
    chk("two_evt0", 32'(evq[m]), 32'h13);
    chk("two_evt1", 32'(evq[m+1]), 32'h1c);

    // 6: reset in the middle of the emit phase
    set_keys(16'h0000);
    wait_frames(4);
    set_keys(16'h1008);
    ok = 1'b0; run = 0;
    for (int i = 0; i < 300; i++) begin
      if (row_n == '1) run++; else run = 0;
      if (run == 2) begin ok = 1'b1; break; end
      tick();
    end
    chk("tmo_emit", 32'(ok), 32'd1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row_n", 32'(row_n), 32'h e);
    chk("mid_rst_valid", 32'(evt_valid), 32'h0);
    chk("mid_rst_state", 32'(key_state), 32'h0);
    chk("mid_rst_any", 32'(any_pressed), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    m = evq.size();
    wait_frames(4);
    chk("re_state", 32'(key_state), 32'h1008);
    chk("re_nevt", 32'(evq.size() - m), 32'd2);
    chk("re_evt0", 32'(evq[m]), 32'h13);
    chk("re_evt1", 32'(evq[m+1]), 32'h1c);

    // 5: back-pressure with five keys -> four stored, one dropped
    set_keys(16'h0000);
    wait_frames(4);
    o = ovf_cnt;
    m = evq.size();
    wait_ones();
    evt_ready = 1'b0;
    keys = 16'h001F;
    wait_frames(4);
    chk("bp_state", 32'(key_state), 32'h001F);
    chk("bp_ovf", 32'(ovf_cnt - o), 32'd1);
    chk("bp_valid", 32'(evt_valid), 32'h1);
    chk("bp_nopop", 32'(evq.size() - m), 32'd0);
    chk("bp_head", 32'({evt_press, evt_code}), 32'h10);
    evt_ready = 1'b1;
    repeat (8) tick();
    chk("drain_nevt", 32'(evq.size() - m), 32'd4);
    for (int i = 0; i < 4; i++) chk("drain_evt", 32'(evq[m+i]), 32'(5'h10 + i));
    chk("drain_valid", 32'(evt_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
Parametrised successor to the 4x4 single-key keypad scanner. It scans an ROWS x COLS active-low key matrix and debounces the whole matrix over several frames. It supports any number of simultaneous keys and reports every press and release as an event through a small FIFO with a valid/ready handshake. It sits between the board keypad pins and the note/control logic, and also exposes the live debounced key bitmap.

Parameters:
ROWS, 4, number of matrix rows driven (row_n); >=2
COLS, 4, number of matrix columns sensed (col_n); >=2
SETTLE_CYCLES, 4, clk cycles each row is driven before its columns are sampled; >=1
DEBOUNCE_FRAMES, 3, consecutive identical full-matrix frames required to commit a change; >=1
FIFO_DEPTH, 4, event FIFO entries; power of two, >=2
(derived) N = ROWS*COLS; CODE_W = clog2(N)

Ports:
clk  in  1  scan clock
rst_n  in  1  asynchronous active-low reset
col_n  in  COLS  column sense, low = key closed on currently driven row
row_n  out  ROWS  row drive, exactly one bit low while scanning
key_state  out  N  debounced bitmap, bit (r*COLS+c) = 1 while key held
any_pressed  out  1  OR of key_state
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts head event
evt_code  out  CODE_W  key code of head event, r*COLS+c
evt_press  out  1  head event type, 1 = press, 0 = release
overflow  out  1  one-cycle pulse per event dropped because FIFO full

Behaviour:
- Clock and reset: a single clock, clk. Reset rst_n is asynchronous and active-low, and every register clears on it.
- Reset values: state S_ROW with row 0 and settle count 0, so row_n = ~1 (4'b1110 at defaults). key_state, raw frame, previous frame, run counter, FIFO pointers and count, evt_valid, overflow and any_pressed are all 0. evt_code and evt_press read 0.
- Key code mapping: row r is driven by row_n[r]. Column c is sensed on col_n[c]. Code = r*COLS + c.
- FSM S_ROW:
  - Drives row_n = ~(1<<row) and counts settle_cnt from 0 to SETTLE_CYCLES-1.
  - In the cycle where settle_cnt = SETTLE_CYCLES-1, raw[row*COLS +: COLS] <= ~col_n.
  - If row < ROWS-1, row increments and settle_cnt resets. Otherwise the FSM goes to S_EVAL.
- FSM S_EVAL (1 cycle):
  - row_n = all ones.
  - run_new = (raw == raw_prev) ? min(run+1, DEBOUNCE_FRAMES) : 1. Then run <= run_new and raw_prev <= raw.
  - Commit when run_new >= DEBOUNCE_FRAMES and raw != key_state. On commit: key_state <= raw, diff <= raw ^ key_state, go to S_EMIT with idx = 0.
  - Otherwise go to S_ROW, row 0.
- FSM S_EMIT:
  - row_n = all ones.
  - Visits idx = 0..N-1, one per cycle, in ascending code order.
  - If diff[idx] = 1, pushes {press = key_state[idx], code = idx}.
  - After idx = N-1, returns to S_ROW, row 0.
  - Scanning is paused for the whole of S_EMIT.
- Frame length: ROWS*SETTLE_CYCLES + 1 cycles with no commit. Add N cycles when a commit occurs.
- Event latency: evt_valid rises the cycle after the push (registered FIFO outputs from the head entry).
- FIFO:
  - Pop occurs when evt_valid && evt_ready.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push is dropped only when full with no pop. The drop asserts overflow for that cycle only.
  - key_state is updated regardless of drops.
  - Pointers wrap modulo FIFO_DEPTH.
  - When empty: evt_ready is ignored and evt_code/evt_press hold their last value.
- any_pressed is combinational from key_state, with no added latency.
- Ghosting: no ghost suppression. The raw matrix is reported as sensed.
- Reset mid-scan or mid-emit aborts immediately. The FIFO is flushed, key_state is cleared and the scan restarts at row 0.

Test Plan (defaults ROWS=COLS=4, SETTLE_CYCLES=2, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4, evt_ready=1 unless stated):
1. Reset, col_n=4'b1111 for 5 frames -> row_n cycles 1110,1101,1011,0111 each for 2 clk, then 1111 for 1 clk (9-clk frame); key_state=0, evt_valid never 1.
2. Hold col_n[2] low whenever row_n=1101 (code 6) -> key_state[6]=1 after S_EVAL of the 2nd frame; exactly one event {press=1, code=6}; any_pressed=1. Remove the key -> after 2 frames, one event {press=0, code=6}, key_state=0.
3. Bounce: code 6 closed for exactly 1 frame, then open -> no event, key_state stays 0.
4. Codes 3 (row0, col3) and 12 (row3, col0) closed in the same frames -> events press/3 then press/12, on consecutive FIFO entries; key_state = 16'h1008.
5. evt_ready=0, five keys (codes 0,1,2,3,4) pressed together -> four entries 0..3 stored, overflow pulses once (at idx 4), key_state=16'h001F. Then evt_ready=1 -> 4 pops in order, evt_valid falls.
6. Assert rst_n during S_EMIT of test 4 -> row_n=1110, evt_valid=0, key_state=0 immediately; with keys still held, events re-occur 2 frames after release of reset.
